// File: rtl/intr_ctrl_pkg.sv
// Shared types and sizes for the interrupt controller.
//  NUM_SRC  number of level-sensitive interrupt sources (one register each)
//  ADDR_W   register index width; NUM_SRC == 2**ADDR_W
//  PRIO_W   priority width; a larger value means a higher priority
package intr_ctrl_pkg;

  localparam int NUM_SRC = 16;
  localparam int ADDR_W  = 4;
  localparam int PRIO_W  = 4;

  typedef logic [PRIO_W-1:0] prio_t;
  typedef logic [ADDR_W-1:0] src_id_t;

  typedef enum logic [1:0] {
    S_IDLE,   // waiting for any active source
    S_VALID,  // presenting a latched id to the CPU
    S_GAP     // one cycle for the serviced source to drop its request
  } intr_state_e;

endpackage

// File: rtl/intr_ctrl_if.sv
// Register bus plus CPU interrupt handshake for intr_ctrl.
//  Bus:       paddr_i, pwdata_i, pwrite_i, penable_i (master -> slave)
//             prdata_o, pready_o                     (slave -> master)
//  Interrupt: intr_active_i, intr_serviced_i         (system/CPU -> slave)
//             intr_to_service_o, intr_valid_o        (slave -> CPU)
// Signal names keep the controller's point of view, so _i means "into intr_ctrl".
interface intr_ctrl_if;
  import intr_ctrl_pkg::*;

  src_id_t              paddr_i;
  prio_t                pwdata_i;
  prio_t                prdata_o;
  logic                 penable_i;
  logic                 pwrite_i;
  logic                 pready_o;
  logic [NUM_SRC-1:0]   intr_active_i;
  src_id_t              intr_to_service_o;
  logic                 intr_valid_o;
  logic                 intr_serviced_i;

  modport slave (
    input  paddr_i, pwdata_i, penable_i, pwrite_i, intr_active_i, intr_serviced_i,
    output prdata_o, pready_o, intr_to_service_o, intr_valid_o
  );

  modport master (
    output paddr_i, pwdata_i, penable_i, pwrite_i, intr_active_i, intr_serviced_i,
    input  prdata_o, pready_o, intr_to_service_o, intr_valid_o
  );

endinterface

// File: rtl/intr_prio_arbiter.sv
// Combinational priority arbiter.
//  prio          per-source priority values
//  intr_active_i level request per source
//  winner        id of the active source with the highest priority (lowest index on ties)
//  any_active    at least one request is active
module intr_prio_arbiter
  import intr_ctrl_pkg::*;
(
  input  prio_t              prio [NUM_SRC],
  input  logic [NUM_SRC-1:0] intr_active_i,
  output src_id_t            winner,
  output logic               any_active
);

  prio_t best_prio;
  logic  found;

  // NOTE: blocking assignments here build a chain of compares; every variable
  // gets a default first so no latch is inferred.
  always_comb begin
    winner    = '0;
    best_prio = '0;
    found     = 1'b0;
    // Strict '>' keeps the earlier (lower) index when priorities are equal.
    for (int i = 0; i < NUM_SRC; i++) begin
      if (intr_active_i[i] && (!found || prio[i] > best_prio)) begin
        found     = 1'b1;
        best_prio = prio[i];
        winner    = src_id_t'(i);
      end
    end
  end

  assign any_active = |intr_active_i;

endmodule

// File: rtl/intr_ctrl.sv
// Register-bus responder and priority interrupt controller.
//  pclk_i  single clock, all logic on the rising edge
//  prst_i  asynchronous active-high reset
//  bus     intr_ctrl_if.slave: priority register window (one register per
//          source, one wait state per transfer) and the CPU valid/serviced
//          interrupt handshake.
// The register bus and the interrupt FSM run independently of each other.
module intr_ctrl
  import intr_ctrl_pkg::*;
(
  input  logic         pclk_i,
  input  logic         prst_i,
  intr_ctrl_if.slave   bus
);

  prio_t       prio_q [NUM_SRC];
  logic        pready_q;
  prio_t       prdata_q;
  intr_state_e state_q;
  src_id_t     intr_id_q;
  logic        intr_valid_q;

  src_id_t     winner;
  logic        any_active;

  // Access phase that is still waiting for its single wait state to elapse.
  logic        bus_start;
  // Access phase that completes on this edge.
  logic        bus_done;

  assign bus_start = bus.penable_i & ~pready_q;
  assign bus_done  = bus.penable_i &  pready_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: the priority registers are reset, because arbitration right after
  // reset must see all priorities as 0.
  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      for (int i = 0; i < NUM_SRC; i++) prio_q[i] <= '0;
      pready_q <= 1'b0;
      prdata_q <= '0;
    end else begin
      // Toggling form gives exactly one wait state, and one transfer per two
      // cycles if penable_i is held high back to back.
      pready_q <= bus_start;
      if (bus_start && !bus.pwrite_i) prdata_q <= prio_q[bus.paddr_i];
      if (bus_done && bus.pwrite_i)   prio_q[bus.paddr_i] <= bus.pwdata_i;
    end
  end

  intr_prio_arbiter u_arbiter (
    .prio          (prio_q),
    .intr_active_i (bus.intr_active_i),
    .winner        (winner),
    .any_active    (any_active)
  );

  // The presented id is latched at arbitration, so source deassertion and
  // priority writes while in S_VALID cannot disturb it.
  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      state_q      <= S_IDLE;
      intr_id_q    <= '0;
      intr_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_active) begin
            intr_id_q    <= winner;
            intr_valid_q <= 1'b1;
            state_q      <= S_VALID;
          end
        end
        S_VALID: begin
          if (bus.intr_serviced_i) begin
            intr_valid_q <= 1'b0;
            state_q      <= S_GAP;
          end
        end
        S_GAP:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.pready_o          = pready_q;
  assign bus.prdata_o          = prdata_q;
  assign bus.intr_to_service_o = intr_id_q;
  assign bus.intr_valid_o      = intr_valid_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: reset state, register read/write timing,
// tie-break and priority arbitration, hold in S_VALID, ignored acks and
// asynchronous reset in the middle of a read and a presented interrupt.
module tb_intr_ctrl;
  import intr_ctrl_pkg::*;

  logic pclk_i;
  logic prst_i;
  int   vectors;
  int   miscompares;

  intr_ctrl_if bus ();

  intr_ctrl dut (
    .pclk_i (pclk_i),
    .prst_i (prst_i),
    .bus    (bus)
  );

  initial pclk_i = 1'b0;
  always #5 pclk_i = ~pclk_i;

  // Advance to just after the next rising edge; all sampling and driving
  // happens at this point, away from the edge.
  task automatic tick;
    @(posedge pclk_i);
    #1;
  endtask

  task automatic bus_read(input src_id_t a, output prio_t d,
                          output logic rdy_mid, output logic rdy_end);
    bus.paddr_i   = a;
    bus.pwrite_i  = 1'b0;
    bus.penable_i = 1'b1;
    tick;
    rdy_mid = bus.pready_o;
    d       = bus.prdata_o;
    tick;
    rdy_end = bus.pready_o;
    bus.penable_i = 1'b0;
  endtask

  task automatic bus_write(input src_id_t a, input prio_t d);
    bus.paddr_i   = a;
    bus.pwdata_i  = d;
    bus.pwrite_i  = 1'b1;
    bus.penable_i = 1'b1;
    tick;
    tick;
    bus.penable_i = 1'b0;
    bus.pwrite_i  = 1'b0;
  endtask

  task automatic test_reset;
    prio_t d;
    logic  rm, re;
    vectors++;
    if ({bus.pready_o, bus.prdata_o, bus.intr_to_service_o, bus.intr_valid_o} !== 10'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rdy=%b rdata=%h id=%h vld=%b, want all 0",
               bus.pready_o, bus.prdata_o, bus.intr_to_service_o, bus.intr_valid_o);
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      bus_read(src_id_t'(i), d, rm, re);
      vectors++;
      if (d !== 4'h0 || rm !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_read[%0d]: got rdata=%h rdy=%b, want rdata=0 rdy=1", i, d, rm);
      end
      vectors++;
      if (re !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_read_rdy_drop[%0d]: got rdy=%b, want 0", i, re);
      end
    end
  endtask

  task automatic test_arbitration;
    // All priorities 0: sources 4 and 9 tie, lower index wins.
    bus.intr_active_i = 16'h0210;
    tick;
    vectors++;
    if (bus.intr_valid_o !== 1'b1 || bus.intr_to_service_o !== 4'd4) begin
      miscompares++;
      $display("FAIL arb_tie: got vld=%b id=%0d, want vld=1 id=4",
               bus.intr_valid_o, bus.intr_to_service_o);
    end
    bus.intr_serviced_i = 1'b1;
    tick;
    vectors++;
    if (bus.intr_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL arb_ack_drop: got vld=%b, want 0", bus.intr_valid_o);
    end
    bus.intr_serviced_i = 1'b0;
    bus.intr_active_i   = 16'h0200;
    tick;
    vectors++;
    if (bus.intr_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL arb_gap: got vld=%b, want 0", bus.intr_valid_o);
    end
    tick;
    vectors++;
    if (bus.intr_valid_o !== 1'b1 || bus.intr_to_service_o !== 4'd9) begin
      miscompares++;
      $display("FAIL arb_next: got vld=%b id=%0d, want vld=1 id=9",
               bus.intr_valid_o, bus.intr_to_service_o);
    end
    bus.intr_serviced_i = 1'b1;
    bus.intr_active_i   = '0;
    tick;
    bus.intr_serviced_i = 1'b0;
    tick;
    tick;
    vectors++;
    if (bus.intr_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL arb_idle: got vld=%b, want 0", bus.intr_valid_o);
    end
  endtask

  task automatic test_write_read;
    prio_t d;
    logic  rm, re;
    bus.paddr_i   = 4'd3;
    bus.pwdata_i  = 4'hA;
    bus.pwrite_i  = 1'b1;
    bus.penable_i = 1'b1;
    tick;
    vectors++;
    if (bus.pready_o !== 1'b1 || dut.prio_q[3] !== 4'h0) begin
      miscompares++;
      $display("FAIL write_wait: got rdy=%b prio3=%h, want rdy=1 prio3=0",
               bus.pready_o, dut.prio_q[3]);
    end
    tick;
    vectors++;
    if (bus.pready_o !== 1'b0 || dut.prio_q[3] !== 4'hA) begin
      miscompares++;
      $display("FAIL write_commit: got rdy=%b prio3=%h, want rdy=0 prio3=a",
               bus.pready_o, dut.prio_q[3]);
    end
    bus.penable_i = 1'b0;
    bus.pwrite_i  = 1'b0;
    tick;
    bus_write(4'd9, 4'h5);
    tick;
    bus_read(4'd3, d, rm, re);
    vectors++;
    if (d !== 4'hA || rm !== 1'b1) begin
      miscompares++;
      $display("FAIL read_prio3: got rdata=%h rdy=%b, want rdata=a rdy=1", d, rm);
    end
    bus_read(4'd9, d, rm, re);
    vectors++;
    if (d !== 4'h5 || rm !== 1'b1) begin
      miscompares++;
      $display("FAIL read_prio9: got rdata=%h rdy=%b, want rdata=5 rdy=1", d, rm);
    end
    tick;
    vectors++;
    if (bus.prdata_o !== 4'h5) begin
      miscompares++;
      $display("FAIL rdata_hold: got %h, want 5", bus.prdata_o);
    end
  endtask

  task automatic test_priority;
    bus.intr_active_i = 16'h0208;
    tick;
    vectors++;
    if (bus.intr_valid_o !== 1'b1 || bus.intr_to_service_o !== 4'd3) begin
      miscompares++;
      $display("FAIL prio_win: got vld=%b id=%0d, want vld=1 id=3",
               bus.intr_valid_o, bus.intr_to_service_o);
    end
    bus.intr_serviced_i = 1'b1;
    tick;
    bus.intr_serviced_i = 1'b0;
    bus.intr_active_i   = 16'h0200;
    tick;
    tick;
    vectors++;
    if (bus.intr_valid_o !== 1'b1 || bus.intr_to_service_o !== 4'd9) begin
      miscompares++;
      $display("FAIL prio_next: got vld=%b id=%0d, want vld=1 id=9",
               bus.intr_valid_o, bus.intr_to_service_o);
    end
  endtask

  task automatic test_hold;
    // Enters with id 9 presented.
    bus.intr_active_i = '0;
    tick;
    vectors++;
    if (bus.intr_valid_o !== 1'b1 || bus.intr_to_service_o !== 4'd9) begin
      miscompares++;
      $display("FAIL hold_deassert: got vld=%b id=%0d, want vld=1 id=9",
               bus.intr_valid_o, bus.intr_to_service_o);
    end
    bus.intr_active_i = 16'h1000;
    bus_write(4'd12, 4'hF);
    vectors++;
    if (bus.intr_valid_o !== 1'b1 || bus.intr_to_service_o !== 4'd9) begin
      miscompares++;
      $display("FAIL hold_write: got vld=%b id=%0d, want vld=1 id=9",
               bus.intr_valid_o, bus.intr_to_service_o);
    end
    bus.intr_serviced_i = 1'b1;
    tick;
    vectors++;
    if (bus.intr_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_ack: got vld=%b, want 0", bus.intr_valid_o);
    end
    bus.intr_serviced_i = 1'b0;
    tick;
    tick;
    vectors++;
    if (bus.intr_valid_o !== 1'b1 || bus.intr_to_service_o !== 4'd12) begin
      miscompares++;
      $display("FAIL hold_next: got vld=%b id=%0d, want vld=1 id=12",
               bus.intr_valid_o, bus.intr_to_service_o);
    end
    bus.intr_serviced_i = 1'b1;
    bus.intr_active_i   = '0;
    tick;
    bus.intr_serviced_i = 1'b0;
    tick;
    tick;
  endtask

  task automatic test_ack_ignored;
    // Ack held high in S_IDLE must not prevent arbitration.
    bus.intr_serviced_i = 1'b1;
    bus.intr_active_i   = 16'h0008;
    tick;
    vectors++;
    if (bus.intr_valid_o !== 1'b1 || bus.intr_to_service_o !== 4'd3) begin
      miscompares++;
      $display("FAIL ack_idle: got vld=%b id=%0d, want vld=1 id=3",
               bus.intr_valid_o, bus.intr_to_service_o);
    end
    tick;
    vectors++;
    if (bus.intr_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL ack_valid: got vld=%b, want 0", bus.intr_valid_o);
    end
    bus.intr_serviced_i = 1'b0;
    bus.intr_active_i   = '0;
    tick;
    tick;
  endtask

  task automatic test_reset_abort;
    prio_t d;
    logic  rm, re;
    bus.intr_active_i = 16'h0008;
    tick;
    bus.paddr_i   = 4'd3;
    bus.pwrite_i  = 1'b0;
    bus.penable_i = 1'b1;
    tick;
    vectors++;
    if (bus.pready_o !== 1'b1 || bus.prdata_o !== 4'hA || bus.intr_valid_o !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset: got rdy=%b rdata=%h vld=%b, want rdy=1 rdata=a vld=1",
               bus.pready_o, bus.prdata_o, bus.intr_valid_o);
    end
    #2 prst_i = 1'b1;
    #1;
    vectors++;
    if ({bus.pready_o, bus.prdata_o, bus.intr_to_service_o, bus.intr_valid_o} !== 10'd0) begin
      miscompares++;
      $display("FAIL async_reset: got rdy=%b rdata=%h id=%h vld=%b, want all 0",
               bus.pready_o, bus.prdata_o, bus.intr_to_service_o, bus.intr_valid_o);
    end
    tick;
    prst_i            = 1'b0;
    bus.penable_i     = 1'b0;
    bus.intr_active_i = '0;
    tick;
    for (int k = 0; k < 3; k++) begin
      src_id_t a;
      a = (k == 0) ? 4'd3 : (k == 1) ? 4'd9 : 4'd12;
      bus_read(a, d, rm, re);
      vectors++;
      if (d !== 4'h0 || rm !== 1'b1) begin
        miscompares++;
        $display("FAIL post_reset_read[%0d]: got rdata=%h rdy=%b, want rdata=0 rdy=1", a, d, rm);
      end
    end
  endtask

  initial begin
    vectors             = 0;
    miscompares         = 0;
    prst_i              = 1'b1;
    bus.paddr_i         = '0;
    bus.pwdata_i        = '0;
    bus.penable_i       = 1'b0;
    bus.pwrite_i        = 1'b0;
    bus.intr_active_i   = '0;
    bus.intr_serviced_i = 1'b0;
    repeat (2) @(posedge pclk_i);
    #1 prst_i = 1'b0;
    tick;

    test_reset;
    test_arbitration;
    test_write_read;
    test_priority;
    test_hold;
    test_ack_ignored;
    test_reset_abort;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
